// File: rtl/both_edge_event_tx.sv
// both_edge_event_tx: transmit side of a both-edge signalling link.
//
// Each accepted event toggles a_out_o exactly once. A downstream both-edge
// detector turns every transition into one event pulse. Bursts are buffered
// in a pending counter. Edges are spaced at least MinHold cycles apart so the
// receiver can resolve every edge.
//
// Optional feature (macro BOTH_EDGE_TX_LOOPBACK_EN):
//   Adds an internal both-edge detector on a_out_o, together with two outputs:
//   - tx_echo_o: one-cycle pulse in the cycle after each toggle.
//   - tx_err_o : sticky flag, set when an echo appears without a matching toggle.
//
// Parameters:
//   MaxPend   pending-event capacity (>= 1)
//   MinHold   minimum cycles a_out_o holds a level after a toggle (>= 1)
//   IdleLevel a_out_o value at reset
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   ev_valid_i  event request
//   ev_ready_o  ready to accept an event (registered state only)
//   flush_i     synchronous discard of all pending events
//   a_out_o     edge-encoded line
//   pend_cnt_o  events accepted but not yet transmitted
//   busy_o      events pending or hold in progress
//   tx_echo_o   (loopback only) echo pulse
//   tx_err_o    (loopback only) sticky echo error
module both_edge_event_tx #(
  parameter int unsigned  MaxPend   = 8,
  parameter int unsigned  MinHold   = 2,
  parameter logic         IdleLevel = 1'b0,
  localparam int unsigned PW        = $clog2(MaxPend + 1),
  localparam int unsigned HW        = $clog2(MinHold) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ev_valid_i,
  output logic          ev_ready_o,
  input  logic          flush_i,
  output logic          a_out_o,
  output logic [PW-1:0] pend_cnt_o,
  output logic          busy_o
`ifdef BOTH_EDGE_TX_LOOPBACK_EN
  ,
  output logic          tx_echo_o,
  output logic          tx_err_o
`endif
);

  localparam logic [PW-1:0] MaxPendW = PW'(MaxPend);
  localparam logic [HW-1:0] HoldInit = HW'(MinHold - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pend_cnt_q, pend_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          a_out_q, a_out_d;
  logic          accept;
  logic          toggle;

  // Ready depends only on registered state, so there is no combinational
  // path from ev_valid_i to ev_ready_o.
  always_comb begin
    ev_ready_o = (pend_cnt_q < MaxPendW);
    accept     = ev_valid_i && ev_ready_o;
    toggle     = (hold_cnt_q == '0) && (pend_cnt_q != '0) && !flush_i;
  end

  // Pending counter. Flush wins over an accept in the same cycle. When an
  // accept and a toggle coincide, the count stays unchanged.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (flush_i) begin
      pend_cnt_d = '0;
    end else if (accept && !toggle) begin
      pend_cnt_d = pend_cnt_q + PW'(1);
    end else if (!accept && toggle) begin
      pend_cnt_d = pend_cnt_q - PW'(1);
    end
  end

  // Line FSM. A running hold keeps counting down through a flush, so a level
  // is never held for less than MinHold cycles.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    a_out_d    = a_out_q;
    unique case (state_q)
      StIdle: begin
        if (toggle) begin
          a_out_d = ~a_out_q;
          // With MinHold == 1 the line may toggle again on the next cycle.
          if (MinHold > 1) begin
            hold_cnt_d = HoldInit;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_q == HW'(1)) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pend_cnt_q <= '0;
      hold_cnt_q <= '0;
      a_out_q    <= IdleLevel;
    end else begin
      state_q    <= state_d;
      pend_cnt_q <= pend_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      a_out_q    <= a_out_d;
    end
  end

  always_comb begin
    a_out_o    = a_out_q;
    pend_cnt_o = pend_cnt_q;
    busy_o     = (pend_cnt_q != '0) || (hold_cnt_q != '0);
  end

`ifdef BOTH_EDGE_TX_LOOPBACK_EN
  logic a_dly_q;
  logic toggled_q;
  logic tx_err_q;

  // The detector sees a_out_o one cycle delayed. An echo is therefore high in
  // the cycle right after a toggle edge, while toggled_q still records that
  // toggle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_dly_q   <= IdleLevel;
      toggled_q <= 1'b0;
      tx_err_q  <= 1'b0;
    end else begin
      a_dly_q   <= a_out_q;
      toggled_q <= toggle;
      tx_err_q  <= tx_err_q | (tx_echo_o & ~toggled_q);
    end
  end

  always_comb begin
    tx_echo_o = a_out_q ^ a_dly_q;
    tx_err_o  = tx_err_q;
  end
`endif

endmodule

// File: tb/tb_both_edge_event_tx.sv
module tb_both_edge_event_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_valid = 1'b1;
  logic flush = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one input vector for n cycles, changing inputs 2 time units after
  // the rising edge.
  task automatic drive(input bit v, input bit f, input bit r, input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      ev_valid = v;
      flush = f;
      rst_n = r;
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned MP = (g == 2) ? 3 : 8;
    localparam int unsigned MH = (g == 0) ? 2 : (g == 1) ? 4 : 1;
    localparam int unsigned PW = $clog2(MP + 1);
    localparam bit          IL = (g == 1);

    logic          ready;
    logic          aout;
    logic          busy;
    logic [PW-1:0] pend;
`ifdef BOTH_EDGE_TX_LOOPBACK_EN
    logic          echo;
    logic          err;
`endif

    both_edge_event_tx #(
      .MaxPend  (MP),
      .MinHold  (MH),
      .IdleLevel(IL)
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ev_valid_i(ev_valid),
      .ev_ready_o(ready),
      .flush_i   (flush),
      .a_out_o   (aout),
      .pend_cnt_o(pend),
      .busy_o    (busy)
`ifdef BOTH_EDGE_TX_LOOPBACK_EN
      ,
      .tx_echo_o (echo),
      .tx_err_o  (err)
`endif
    );

    // Reference model. It tracks the pending count and the earliest edge at
    // which the next toggle is allowed. Each toggle pushes its edge index to
    // the scoreboard queue.
    int exp_q[$];
    int pend_m = 0;
    int next_ok = 0;
    int e = 0;
    int last_tog = -1;
    bit lvl = IL;

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend_m = 0;
        next_ok = 0;
        lvl = IL;
        last_tog = -1;
        exp_q.delete();
      end else begin
        bit acc;
        bit tog;
        e++;
        acc = ev_valid && (pend_m < int'(MP));
        tog = (e >= next_ok) && (pend_m != 0) && !flush;
        if (flush) pend_m = 0;
        else pend_m = pend_m + int'(acc) - int'(tog);
        if (tog) begin
          lvl = ~lvl;
          next_ok = e + int'(MH);
          last_tog = e;
          exp_q.push_back(e);
        end
      end
    end

    // Monitor: compare the DUT state every cycle. Pop the scoreboard whenever
    // a_out moves.
    bit prev = IL;
    initial forever begin
      @(negedge clk);
      chk($sformatf("c%0d pend_cnt", g), int'(pend), pend_m);
      chk($sformatf("c%0d ev_ready", g), int'(ready), int'(pend_m < int'(MP)));
      chk($sformatf("c%0d busy", g), int'(busy), int'((pend_m != 0) || (e + 1 < next_ok)));
      chk($sformatf("c%0d a_out", g), int'(aout), int'(lvl));
`ifdef BOTH_EDGE_TX_LOOPBACK_EN
      chk($sformatf("c%0d tx_echo", g), int'(echo), int'(rst_n && last_tog == e));
      chk($sformatf("c%0d tx_err", g), int'(err), 0);
`endif
      if (rst_n && (aout != prev)) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("c%0d unexpected_toggle_edge", g), e, -1);
        end else begin
          chk($sformatf("c%0d toggle_edge", g), e, exp_q.pop_front());
        end
      end
      prev = aout;
    end
  end

  initial begin
    // Reset held with ev_valid high. Nothing may be accepted.
    drive(1, 0, 0, 3);
    drive(0, 0, 1, 3);
    // Single event.
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 10);
    // Burst of three.
    drive(1, 0, 1, 3);
    drive(0, 0, 1, 14);
    // Hold valid to fill the slower configurations, then drain.
    drive(1, 0, 1, 60);
    drive(0, 0, 1, 40);
    // Five events, then a flush mid-hold with a simultaneous offer.
    drive(1, 0, 1, 5);
    drive(0, 0, 1, 2);
    drive(1, 1, 1, 1);
    drive(0, 0, 1, 12);
    // Reset mid-burst.
    drive(1, 0, 1, 6);
    drive(1, 0, 0, 2);
    drive(0, 0, 1, 10);
    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 399) != 0, 1);
    end
    drive(0, 0, 1, 60);
    @(negedge clk);
    chk("c0 scoreboard_drained", g_cfg[0].exp_q.size(), 0);
    chk("c1 scoreboard_drained", g_cfg[1].exp_q.size(), 0);
    chk("c2 scoreboard_drained", g_cfg[2].exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
